// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of an 8x8 synchronous memory.
// After reset it sweeps INIT_VAL into every word, then grants one port per cycle, alternating on contention.
module mem_arbiter #(
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic       a_rvalid,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_gnt,
    output logic       b_rvalid,
    output logic [7:0] b_rdata,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] mem_rdaddr,
    output logic [2:0] mem_wraddr,
    output logic [7:0] mem_in,
    input  logic [7:0] mem_out,
    output logic       busy
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(7);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_b_q, last_b_d;   // 1: port B granted most recently, so A wins a tie
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;

    // State register; reset restarts the sweep and favours port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Next-state, arbitration and memory command decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_b_d   = last_b_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_rdaddr = '0;
        mem_wraddr = '0;
        mem_in     = DW'(0);
        busy       = 1'b1;

        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    mem_wr     = 1'b1;
                    mem_wraddr = cnt_q;
                    mem_in     = INIT_VAL;
                    cnt_d      = cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    busy = 1'b0;
                    if (a_req && (!b_req || last_b_q)) begin
                        a_gnt = 1'b1;
                    end else if (b_req) begin
                        b_gnt = 1'b1;
                    end

                    if (a_gnt) begin
                        last_b_d   = 1'b0;
                        mem_wr     = a_we;
                        mem_rd     = !a_we;
                        mem_wraddr = a_addr;
                        mem_rdaddr = a_addr;
                        mem_in     = a_wdata;
                        a_rvalid_d = !a_we;
                    end else if (b_gnt) begin
                        last_b_d   = 1'b1;
                        mem_wr     = b_we;
                        mem_rd     = !b_we;
                        mem_wraddr = b_addr;
                        mem_rdaddr = b_addr;
                        mem_in     = b_wdata;
                        b_rvalid_d = !b_we;
                    end
                end
            endcase
        end
    end

    // A read in flight when reset arrives must not surface as valid data.
    assign a_rvalid = a_rvalid_q & ~rst;
    assign b_rvalid = b_rvalid_q & ~rst;
    assign a_rdata  = mem_out;
    assign b_rdata  = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

    localparam logic [7:0] INIT_VAL = 8'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_rd, mem_wr;
    logic [2:0] mem_rdaddr, mem_wraddr;
    logic [7:0] mem_in;
    logic [7:0] mem_out = 8'h00;
    logic       busy;

    always #5 clk = ~clk;

    mem_arbiter #(.INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdaddr(mem_rdaddr),
        .mem_wraddr(mem_wraddr), .mem_in(mem_in), .mem_out(mem_out),
        .busy(busy)
    );

    // Attached 8x8 synchronous memory, preloaded with garbage so the sweep matters.
    logic [7:0] bmem [8];
    initial for (int i = 0; i < 8; i++) bmem[i] = 8'hFF;
    always @(posedge clk) begin
        if (mem_wr) bmem[mem_wraddr] <= mem_in;
        if (mem_rd) mem_out <= bmem[mem_rdaddr];
    end

    // Reference model state.
    bit         m_init = 1'b1;
    int         m_cnt = 0;
    bit         m_pref_a = 1'b1;
    bit         m_pend_a = 1'b0, m_pend_b = 1'b0;
    logic [7:0] m_rd_a = 8'h00, m_rd_b = 8'h00;
    logic [7:0] m_mem [8];
    bit         m_ga, m_gb;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit r,
                       input bit ar, input bit aw, input logic [2:0] aa, input logic [7:0] ad,
                       input bit br, input bit bw, input logic [2:0] ba, input logic [7:0] bd);
        bit         e_busy, e_ga, e_gb, e_wr, e_rd, e_rva, e_rvb;
        logic [2:0] e_wa, e_ra;
        logic [7:0] e_in;
        @(posedge clk);
        #1;
        rst = r;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk);

        e_busy = 1'b1; e_ga = 1'b0; e_gb = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        e_wa = 3'd0; e_ra = 3'd0; e_in = 8'h00;
        if (r) begin
            e_busy = 1'b1;
        end else if (m_init) begin
            e_wr = 1'b1;
            e_wa = m_cnt[2:0];
            e_in = INIT_VAL;
        end else begin
            e_busy = 1'b0;
            e_ga = ar && (!br || m_pref_a);
            e_gb = br && !e_ga;
            if (e_ga) begin
                e_wr = aw; e_rd = !aw; e_wa = aa; e_ra = aa; e_in = ad;
            end else if (e_gb) begin
                e_wr = bw; e_rd = !bw; e_wa = ba; e_ra = ba; e_in = bd;
            end
        end
        e_rva = !r && m_pend_a;
        e_rvb = !r && m_pend_b;

        check("busy", 32'(busy), 32'(e_busy));
        check("a_gnt", 32'(a_gnt), 32'(e_ga));
        check("b_gnt", 32'(b_gnt), 32'(e_gb));
        check("mem_wr", 32'(mem_wr), 32'(e_wr));
        check("mem_rd", 32'(mem_rd), 32'(e_rd));
        if (e_wr) begin
            check("mem_wraddr", 32'(mem_wraddr), 32'(e_wa));
            check("mem_in", 32'(mem_in), 32'(e_in));
        end
        if (e_rd) check("mem_rdaddr", 32'(mem_rdaddr), 32'(e_ra));
        check("a_rvalid", 32'(a_rvalid), 32'(e_rva));
        check("b_rvalid", 32'(b_rvalid), 32'(e_rvb));
        if (e_rva) check("a_rdata", 32'(a_rdata), 32'(m_rd_a));
        if (e_rvb) check("b_rdata", 32'(b_rdata), 32'(m_rd_b));

        if (r) begin
            m_init = 1'b1; m_cnt = 0; m_pref_a = 1'b1;
            m_pend_a = 1'b0; m_pend_b = 1'b0;
        end else if (m_init) begin
            m_mem[m_cnt] = INIT_VAL;
            m_cnt++;
            if (m_cnt == 8) m_init = 1'b0;
            m_pend_a = 1'b0; m_pend_b = 1'b0;
        end else begin
            m_pend_a = e_ga && !aw;
            m_pend_b = e_gb && !bw;
            if (m_pend_a) m_rd_a = m_mem[aa];
            if (m_pend_b) m_rd_b = m_mem[ba];
            if (e_ga) begin
                if (aw) m_mem[aa] = ad;
                m_pref_a = 1'b0;
            end
            if (e_gb) begin
                if (bw) m_mem[ba] = bd;
                m_pref_a = 1'b1;
            end
        end
        m_ga = e_ga;
        m_gb = e_gb;
    endtask

    task automatic idle(input bit r);
        cyc(r, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    bit         pa, pb, pawe, pbwe, r;
    logic [2:0] paad, pbad;
    logic [7:0] pad, pbd;

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 3'd0; a_wdata = 8'h00;
        b_req = 1'b0; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
        for (int i = 0; i < 8; i++) m_mem[i] = 8'hFF;

        // Reset, full sweep, then read address 5.
        idle(1'b1);
        idle(1'b1);
        repeat (8) idle(1'b0);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
        idle(1'b0);

        // Write then read back on port A.
        cyc(1'b0, 1'b1, 1'b1, 3'd2, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        idle(1'b0);

        // Reset mid-sweep, both ports requesting through the restarted sweep and beyond.
        idle(1'b1);
        repeat (4) idle(1'b0);
        idle(1'b1);
        repeat (14) cyc(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);

        // Same-address writes, A first then B; B's value must stick.
        cyc(1'b0, 1'b1, 1'b1, 3'd7, 8'hAA, 1'b1, 1'b1, 3'd7, 8'h55);
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 3'd7, 8'h55);
        cyc(1'b0, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        idle(1'b0);

        // B read granted, reset the next cycle.
        cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd4, 8'h00);
        idle(1'b1);
        idle(1'b0);
        repeat (8) idle(1'b0);

        // Random traffic with occasional resets.
        pa = 1'b0; pb = 1'b0;
        pawe = 1'b0; pbwe = 1'b0; paad = 3'd0; pbad = 3'd0; pad = 8'h00; pbd = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1'b1; pawe = 1'($urandom_range(0, 1));
                paad = 3'($urandom_range(0, 7)); pad = 8'($urandom);
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1'b1; pbwe = 1'($urandom_range(0, 1));
                pbad = 3'($urandom_range(0, 7)); pbd = 8'($urandom);
            end
            r = ($urandom_range(0, 79) == 0);
            cyc(r, pa, pawe, paad, pad, pb, pbwe, pbad, pbd);
            if (m_ga) pa = 1'b0;
            if (m_gb) pb = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: INIT_VAL, default 8'h00, the value written to every memory word during the init sweep.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a_req  input  1  port A access request.
REQ-006 a_we  input  1  port A: 1 = write, 0 = read.
REQ-007 a_addr  input  3  port A word address.
REQ-008 a_wdata  input  8  port A write data.
REQ-009 a_gnt  output  1  port A granted this cycle (combinational).
REQ-010 a_rvalid  output  1  port A read data valid (registered).
REQ-011 a_rdata  output  8  port A read data; equals mem_out.
REQ-012 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B, same directions, widths and meanings as port A.
REQ-013 mem_rd  output  1  read enable to the 8x8 synchronous memory.
REQ-014 mem_wr  output  1  write enable to the memory.
REQ-015 mem_rdaddr  output  3  memory read address.
REQ-016 mem_wraddr  output  3  memory write address.
REQ-017 mem_in  output  8  memory write data.
REQ-018 mem_out  input  8  memory read data; valid the cycle after mem_rd.
REQ-019 busy  output  1  init sweep in progress; no grants while high.

Function
REQ-020 The block SHALL have two states: INIT (sweep) and RUN (arbitrate).
REQ-021 INIT: a 3-bit counter SHALL run 0..7; each cycle mem_wr=1, mem_wraddr=counter, mem_in=INIT_VAL, mem_rd=0, busy=1, a_gnt=b_gnt=0.
REQ-022 After the cycle with counter=7, the state SHALL go to RUN (exactly 8 write cycles); busy SHALL be 0 from the first RUN cycle.
REQ-023 RUN: at most one grant per cycle; a_gnt and b_gnt SHALL never be high together.
REQ-024 A lone requester SHALL be granted in the same cycle its req is high.
REQ-025 With a_req and b_req both high, the port not granted most recently SHALL win; the 1-bit last-grant pointer SHALL update only on a grant.
REQ-026 Granted write: mem_wr=1, mem_wraddr=addr, mem_in=wdata, mem_rd=0.
REQ-027 Granted read: mem_rd=1, mem_rdaddr=addr, mem_wr=0; the port's rvalid SHALL be 1 exactly one cycle later, for one cycle.
REQ-028 No grant: mem_rd=mem_wr=0; address and data outputs are don't-care.
REQ-029 Requesters SHALL hold req, we, addr and wdata stable until gnt; a denied request is neither dropped nor reordered.
REQ-030 A write granted in cycle N SHALL be visible to a read granted in cycle N+1 or later.
REQ-031 a_rdata and b_rdata are meaningful only while the matching rvalid is high.

Reset
REQ-032 With rst high at a posedge, the state SHALL go to INIT with counter=0, the pointer SHALL prefer port A, and both rvalid flags SHALL clear.
REQ-033 While rst is high: mem_wr=mem_rd=0, a_gnt=b_gnt=0, busy=1.
REQ-034 A reset mid-sweep or mid-RUN SHALL restart the full 8-cycle sweep; a read pending at reset SHALL NOT produce rvalid.

Verification
REQ-035 Release rst -> 8 cycles of mem_wr with mem_wraddr 0..7 and mem_in=8'h00, busy=1 throughout, then busy=0; a read of address 5 returns 8'h00.
REQ-036 A writes 8'h3C to address 2, then A reads address 2 -> a_gnt in the request cycle, a_rvalid one cycle after the read grant, a_rdata=8'h3C, b_rvalid stays 0.
REQ-037 A and B request continuously from the first RUN cycle -> grants alternate A,B,A,B; never both high.
REQ-038 Assert rst at sweep counter=4 -> the sweep restarts at address 0 and runs 8 full cycles; no grants during the sweep.
REQ-039 A writes 8'hAA and B writes 8'h55 to address 7 in the same cycle, with A granted first -> the next read of address 7 returns 8'h55.
REQ-040 B read granted with rst asserted in the following cycle -> b_rvalid stays 0 and busy=1.
